sbox_feed_ctrl: RTL and testbench
=================================

SBOX_FEED_CTRL -- requirements
Module: sbox_feed_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 16: number of state bytes per run.
REQ-002 SHALL have parameter LAT, default 2: cycles from sb_issue to the matching res_valid (two-stage masked S-box depth).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle pulse requesting a run.
REQ-006 SHALL have port st_s0  in  8*NBYTES  share 0 of the state; byte i = bits [8i+7:8i].
REQ-007 SHALL have port st_s1  in  8*NBYTES  share 1 of the state, same layout.
REQ-008 SHALL have port rnd_valid  in  1  a fresh random byte is offered.
REQ-009 SHALL have port rnd_data  in  8  the offered random byte.
REQ-010 SHALL have port rnd_ready  out  1  the block accepts rnd_data this cycle.
REQ-011 SHALL have port sb_s0  out  8  share-0 byte to Stage-1; bit0=a0 ... bit7=h0.
REQ-012 SHALL have port sb_s1  out  8  share-1 byte to Stage-1, same bit order.
REQ-013 SHALL have port sb_ran  out  8  fresh randomness to Stage-1, bit7=r0m ... bit0=r7m.
REQ-014 SHALL have port sb_issue  out  1  sb_s0, sb_s1 and sb_ran carry a valid byte this cycle.
REQ-015 SHALL have port res_valid  out  1  the downstream S-box output is valid this cycle.
REQ-016 SHALL have port res_idx  out  clog2(NBYTES)  byte index of the result marked by res_valid.
REQ-017 SHALL have port busy  out  1  a run is in progress.
REQ-018 SHALL have port done  out  1  one-cycle pulse when a run completes.

Function
REQ-019 SHALL implement the FSM states IDLE, RUN and DRAIN.
REQ-020 In IDLE, start=1 SHALL capture st_s0 and st_s1 into separate share registers, clear idx to 0 and move to RUN; busy SHALL be 1 from the next cycle.
REQ-021 The block SHALL ignore start whenever it is not in IDLE.
REQ-022 rnd_ready SHALL be 1 only in RUN, and SHALL be 0 in the RUN cycle after the last byte has been accepted.
REQ-023 A handshake (rnd_valid & rnd_ready) in cycle n SHALL register byte idx of both shares, plus rnd_data, onto sb_s0, sb_s1 and sb_ran, with sb_issue=1 in cycle n+1, then increment idx.
REQ-024 In any cycle without an issue, sb_s0, sb_s1 and sb_ran SHALL all be 0 and sb_issue SHALL be 0, so no stale share or mask persists.
REQ-025 Each accepted random byte SHALL be used for exactly one issue and never reused; if rnd_valid=0, the block SHALL stall without issuing.
REQ-026 Share 0 and share 1 SHALL never be combined by any logic inside the block, and all sb_* outputs SHALL be driven directly from flops (no glitchy combinational paths).
REQ-027 The handshake for byte NBYTES-1 SHALL move the FSM to DRAIN.
REQ-028 res_valid and res_idx SHALL be an LAT-deep delay line of sb_issue and its idx, so res_valid is high exactly LAT cycles after the matching sb_issue.
REQ-029 In DRAIN, the FSM SHALL wait until the delay line is empty after the last res_valid, then pulse done=1 for one cycle with busy=0 in that same cycle, and return to IDLE.
REQ-030 A start arriving in the same cycle as done SHALL be ignored; the block SHALL accept start from the next cycle.
REQ-031 idx SHALL NOT wrap within a run; the issue count per run SHALL be exactly NBYTES.

Reset
REQ-032 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE, and idx, the delay line, the share registers and all outputs SHALL be cleared to 0.
REQ-033 rst_n=0 SHALL take priority over start.
REQ-034 Reset mid-run SHALL abort the run: no further res_valid and no done pulse.

Verification
REQ-035 The bench SHALL cover: start at cycle 0 with rnd_valid held 1 -> sb_issue in cycles 2..17, res_valid in cycles 4..19 with res_idx 0..15, done=1 and busy=0 at cycle 20.
REQ-036 The bench SHALL cover: rnd_valid low for 3 cycles after byte 5 -> no sb_issue in those cycles, sb_* = 0 there, and byte 6 issued once rnd_valid returns, with no byte skipped or duplicated.
REQ-037 The bench SHALL cover: st_s0 byte 0 = 0x53, st_s1 byte 0 = 0xA1, rnd_data = 0x3C -> sb_s0=0x53, sb_s1=0xA1 and sb_ran=0x3C in the first issue cycle.
REQ-038 The bench SHALL cover: start pulsed again during RUN -> ignored, with exactly 16 issues and a single done.
REQ-039 The bench SHALL cover: rst_n=0 after 7 issues -> all outputs 0 the next cycle, and no res_valid or done afterwards.
REQ-040 The bench SHALL check that the random stream is consumed in order: accepted bytes 0x01..0x10 appear on sb_ran in the same order, each exactly once.

Source files
------------

// File: rtl/sbox_feed_ctrl.sv
// Feeds a two-share masked S-box one state byte per cycle, pairing each byte with one fresh
// random byte, and tracks the S-box latency so the caller sees res_valid/res_idx and a done pulse.
module sbox_feed_ctrl #(
    parameter int NBYTES = 16,
    parameter int LAT    = 2,
    localparam int IW    = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*NBYTES-1:0] st_s0,
    input  logic [8*NBYTES-1:0] st_s1,
    input  logic                rnd_valid,
    input  logic [7:0]          rnd_data,
    output logic                rnd_ready,
    output logic [7:0]          sb_s0,
    output logic [7:0]          sb_s1,
    output logic [7:0]          sb_ran,
    output logic                sb_issue,
    output logic                res_valid,
    output logic [IW-1:0]       res_idx,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_dbg
);

    // Random-byte handshake: a byte is taken in any cycle where rnd_valid and rnd_ready are
    // both 1; rnd_ready depends only on the FSM state, never on rnd_valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    sh0_q [NBYTES];
    logic [7:0]    sh1_q [NBYTES];
    logic [IW-1:0] idx_q;
    logic [IW-1:0] sb_idx_q;
    logic [LAT-1:0] pv_q;
    logic [IW-1:0] pi_q [LAT];
    logic          hs;
    logic          last_byte;
    logic          pipe_empty;
    logic          load;

    assign rnd_ready  = (state_q == RUN);
    assign hs         = rnd_valid & rnd_ready;
    assign last_byte  = (idx_q == IW'(NBYTES - 1));
    assign pipe_empty = !sb_issue && (pv_q == '0);
    assign res_valid  = pv_q[LAT-1];
    assign res_idx    = pi_q[LAT-1];
    assign state_dbg  = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (hs && last_byte) state_d = DRAIN;
            end
            DRAIN: begin
                // done replaces busy in the single cycle the pipeline is seen empty
                if (pipe_empty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shares stay in separate registers and separate muxes end to end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NBYTES; i++) begin
                sh0_q[i] <= '0;
                sh1_q[i] <= '0;
            end
            idx_q    <= '0;
            sb_idx_q <= '0;
            sb_s0    <= '0;
            sb_s1    <= '0;
            sb_ran   <= '0;
            sb_issue <= 1'b0;
            pv_q     <= '0;
            for (int k = 0; k < LAT; k++) pi_q[k] <= '0;
        end else begin
            if (load) begin
                for (int i = 0; i < NBYTES; i++) begin
                    sh0_q[i] <= st_s0[8*i +: 8];
                    sh1_q[i] <= st_s1[8*i +: 8];
                end
                idx_q <= '0;
            end else if (hs && !last_byte) begin
                idx_q <= idx_q + 1'b1;
            end
            sb_issue <= hs;
            sb_s0    <= hs ? sh0_q[idx_q] : 8'h00;
            sb_s1    <= hs ? sh1_q[idx_q] : 8'h00;
            sb_ran   <= hs ? rnd_data     : 8'h00;
            sb_idx_q <= hs ? idx_q        : '0;
            pv_q[0]  <= sb_issue;
            pi_q[0]  <= sb_idx_q;
            for (int k = 1; k < LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pi_q[k] <= pi_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_sbox_feed_ctrl.sv
// Directed bench for sbox_feed_ctrl: a cycle table for a full run, then a stall run against a
// scoreboard, then a mid-run reset.
module tb_sbox_feed_ctrl;

    localparam int NB  = 16;
    localparam int LAT = 2;
    localparam int W   = 24;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [8*NB-1:0] st_s0, st_s1;
    logic            rnd_valid = 1'b0;
    logic [7:0]      rnd_data = 8'h00;
    logic            rnd_ready;
    logic [7:0]      sb_s0, sb_s1, sb_ran;
    logic            sb_issue, res_valid, busy, done;
    logic [3:0]      res_idx;
    logic [1:0]      state_dbg;

    int n_pass = 0;
    int n_chk  = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic       start;
        logic [7:0] data;
        logic       rdy;
        logic       iss;
        logic [7:0] s0, s1, ran;
        logic       rv;
        logic [3:0] ri;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[23];

    sbox_feed_ctrl #(.NBYTES(NB), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .st_s0(st_s0), .st_s1(st_s1),
        .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
        .sb_s0(sb_s0), .sb_s1(sb_s1), .sb_ran(sb_ran), .sb_issue(sb_issue),
        .res_valid(res_valid), .res_idx(res_idx), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] b0(input int i);
        return (i == 0) ? 8'h53 : 8'(i * 17 + 7);
    endfunction

    function automatic logic [7:0] b1(input int i);
        return (i == 0) ? 8'hA1 : 8'(240 - 3 * i);
    endfunction

    function automatic logic [63:0] pack(input logic rdy, input logic iss, input logic [7:0] s0,
                                         input logic [7:0] s1, input logic [7:0] ran,
                                         input logic rv, input logic [3:0] ri,
                                         input logic bsy, input logic dn);
        return {31'd0, rdy, iss, s0, s1, ran, rv, ri, bsy, dn};
    endfunction

    function automatic logic [63:0] out_vec();
        return pack(rnd_ready, sb_issue, sb_s0, sb_s1, sb_ran, res_valid, res_idx, busy, done);
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        logic [W-1:0] ex;
        logic exp_iss[64];
        logic exp_rv[64];
        logic [3:0] exp_ri[64];
        logic exp_ready;
        int n_iss, n_done, k, done_cyc, last_rv;

        for (int i = 0; i < NB; i++) begin
            st_s0[8*i +: 8] = b0(i);
            st_s1[8*i +: 8] = b1(i);
        end

        // Full-run table: start in cycle 0 (again at 5 and at 20, both ignored), restart at 21.
        for (int c = 0; c < 23; c++) begin
            tbl[c].start = (c == 0) || (c == 5) || (c == 20) || (c == 21);
            tbl[c].data  = 8'(c);
            tbl[c].rdy   = (c >= 1 && c <= 16) || (c == 22);
            tbl[c].iss   = (c >= 2 && c <= 17);
            tbl[c].s0    = tbl[c].iss ? b0(c - 2) : 8'h00;
            tbl[c].s1    = tbl[c].iss ? b1(c - 2) : 8'h00;
            tbl[c].ran   = tbl[c].iss ? 8'(c - 1) : 8'h00;
            tbl[c].rv    = (c >= 4 && c <= 19);
            tbl[c].ri    = tbl[c].rv ? 4'(c - 4) : 4'h0;
            tbl[c].busy  = (c >= 1 && c <= 19) || (c == 22);
            tbl[c].done  = (c == 20);
        end

        // Reset with start held high: reset wins.
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) step();
        check("reset_outputs", out_vec(), 64'd0);
        check("reset_state", 64'(state_dbg), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        check("idle_after_reset", {out_vec(), 2'(state_dbg)}, 66'd0);

        // Run 1: table-driven, random stream 0x01..0x10 with rnd_valid held 1.
        for (int i = 0; i < NB; i++) exp_q.push_back({b0(i), b1(i), 8'(i + 1)});
        n_iss  = 0;
        n_done = 0;
        rnd_valid = 1'b1;
        for (int c = 0; c < 23; c++) begin
            check($sformatf("run1_cycle%0d", c), out_vec(),
                  pack(tbl[c].rdy, tbl[c].iss, tbl[c].s0, tbl[c].s1, tbl[c].ran,
                       tbl[c].rv, tbl[c].ri, tbl[c].busy, tbl[c].done));
            if (sb_issue && c <= 20) begin
                n_iss++;
                if (exp_q.size() > 0) begin
                    ex = exp_q.pop_front();
                    check("run1_stream_order", {sb_s0, sb_s1, sb_ran}, ex);
                end else begin
                    check("run1_extra_issue", 64'(n_iss), 64'(NB));
                end
            end
            if (done && c <= 20) n_done++;
            start    = tbl[c].start;
            rnd_data = tbl[c].data;
            step();
        end
        check("run1_issue_count", 64'(n_iss), 64'(NB));
        check("run1_done_count", 64'(n_done), 64'd1);
        check("run1_queue_empty", 64'(exp_q.size()), 64'd0);
        start = 1'b0;
        rnd_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("abort_restart_idle", out_vec(), 64'd0);

        // Run 2: rnd_valid low for 3 cycles after byte 5, first random byte 0x3C.
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_iss[i] = 1'b0;
            exp_rv[i]  = 1'b0;
            exp_ri[i]  = 4'h0;
        end
        k = 0;
        n_iss = 0;
        n_done = 0;
        done_cyc = -1;
        last_rv = 0;
        for (int c = 0; c < 60; c++) begin
            exp_ready = (c >= 1) && (k < NB);
            check("run2_issue", 64'(sb_issue), 64'(exp_iss[c]));
            if (exp_iss[c] && exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                check("run2_data", {sb_s0, sb_s1, sb_ran}, ex);
            end else if (!exp_iss[c]) begin
                check("run2_zero", {sb_s0, sb_s1, sb_ran}, 64'd0);
            end
            check("run2_res", {res_valid, res_idx}, {exp_rv[c], exp_ri[c]});
            check("run2_ready", 64'(rnd_ready), 64'(exp_ready));
            if (sb_issue) n_iss++;
            if (done) begin
                n_done++;
                done_cyc = c;
            end
            start     = (c == 0);
            rnd_valid = !(c >= 7 && c <= 9);
            rnd_data  = (c == 1) ? 8'h3C : 8'(8'h80 + c);
            if (exp_ready && rnd_valid) begin
                exp_q.push_back({b0(k), b1(k), rnd_data});
                exp_iss[c+1]       = 1'b1;
                exp_rv[c+1+LAT]    = 1'b1;
                exp_ri[c+1+LAT]    = 4'(k);
                last_rv            = c + 1 + LAT;
                k++;
            end
            step();
            if (done_cyc >= 0) break;
        end
        check("run2_done_cycle", 64'(done_cyc), 64'(last_rv + 1));
        check("run2_issue_count", 64'(n_iss), 64'(NB));
        check("run2_done_count", 64'(n_done), 64'd1);
        check("run2_queue_empty", 64'(exp_q.size()), 64'd0);

        // Run 3: reset after 7 issues aborts the run.
        n_iss = 0;
        rnd_valid = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (sb_issue) n_iss++;
            start    = (c == 0);
            rnd_data = 8'(c);
            if (c == 8) rst_n = 1'b0;
            step();
        end
        check("run3_issues_before_reset", 64'(n_iss), 64'd7);
        check("run3_outputs_after_reset", {out_vec(), 2'(state_dbg)}, 66'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            check("run3_quiet_after_reset", {60'd0, res_valid, done, busy, sb_issue}, 64'd0);
        end

        // final report
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
